// File: rtl/motor_shutdown_seq.sv
// Motor shutdown sequencer: on a watchdog shutdown it ramps the PWM duty down, brakes and latches the fault.
// Build option MOTOR_SHUTDOWN_SOFT_RAMP_EN selects stepped ramps; otherwise the ramps are single-cycle jumps.
module motor_shutdown_seq #(
  parameter int RAMP_STEP   = 16,
  parameter int RAMP_DIV    = 4,
  parameter int REARM_QUIET = 250
) (
  input  logic       clk_1khz,
  input  logic       rst,
  input  logic       shtdwn_in,
  input  logic [7:0] duty_cmd,
  input  logic       restart_req,
  output logic [7:0] duty_out,
  output logic       motor_en,
  output logic       brake,
  output logic       fault_latched,
  output logic [3:0] fault_cnt,
  output logic       restart_nack,
  output logic [1:0] state
);

`ifdef MOTOR_SHUTDOWN_SOFT_RAMP_EN
  localparam bit SOFT_RAMP = 1'b1;
`else
  localparam bit SOFT_RAMP = 1'b0;
`endif

  localparam int DIV_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int QUIET_W = $clog2(REARM_QUIET + 1);
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(RAMP_DIV - 1);
  localparam logic [QUIET_W-1:0] QUIET_MAX = QUIET_W'(REARM_QUIET);
  localparam logic [8:0]         STEP9     = 9'(RAMP_STEP);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_RAMP  = 2'd1,
    ST_HALT  = 2'd2,
    ST_REARM = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         duty_q, duty_d;
  logic               motor_en_q, motor_en_d;
  logic               brake_q, brake_d;
  logic               fault_q, fault_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               nack_q, nack_d;
  logic [QUIET_W-1:0] quiet_q, quiet_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               rr_q, rr_d;

  logic               restart_edge;
  logic               step_tick;
  logic [8:0]         up9;
  logic [7:0]         duty_up;
  logic [7:0]         duty_dn;
  logic [3:0]         cnt_inc;

  always_comb begin
    rr_d         = restart_req;
    restart_edge = restart_req & ~rr_q;
    step_tick    = (div_q == DIV_LAST);
    // 9-bit sum so a large step near 255 clamps to the command instead of wrapping
    up9          = {1'b0, duty_q} + STEP9;
    duty_up      = (up9 > {1'b0, duty_cmd}) ? duty_cmd : up9[7:0];
    duty_dn      = ({1'b0, duty_q} > STEP9) ? (duty_q - STEP9[7:0]) : 8'd0;
    cnt_inc      = (cnt_q == 4'hF) ? 4'hF : (cnt_q + 4'd1);

    state_d = state_q;
    duty_d  = duty_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    nack_d  = 1'b0;
    quiet_d = '0;
    div_d   = step_tick ? '0 : (div_q + DIV_W'(1));

    case (state_q)
      ST_RUN: begin
        duty_d = duty_cmd;
        if (shtdwn_in) begin
          state_d = ST_RAMP;
          fault_d = 1'b1;
          cnt_d   = cnt_inc;
          div_d   = '0;
          duty_d  = SOFT_RAMP ? duty_q : 8'd0;
        end
      end
      ST_RAMP: begin
        if (SOFT_RAMP) begin
          if (step_tick) begin
            duty_d = duty_dn;
            if (duty_dn == 8'd0) state_d = ST_HALT;
          end
        end else begin
          duty_d  = 8'd0;
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        duty_d = 8'd0;
        if (shtdwn_in)               quiet_d = '0;
        else if (quiet_q == QUIET_MAX) quiet_d = quiet_q;
        else                         quiet_d = quiet_q + QUIET_W'(1);
        // A shutdown coinciding with the restart edge always wins
        if (restart_edge) begin
          if (!shtdwn_in && (quiet_q == QUIET_MAX)) begin
            state_d = ST_REARM;
            div_d   = '0;
          end else begin
            nack_d = 1'b1;
          end
        end
      end
      ST_REARM: begin
        if (shtdwn_in) begin
          state_d = ST_RAMP;
          cnt_d   = cnt_inc;
          div_d   = '0;
          duty_d  = SOFT_RAMP ? duty_q : 8'd0;
        end else if (SOFT_RAMP) begin
          if (step_tick) begin
            duty_d = duty_up;
            if (duty_up == duty_cmd) begin
              state_d = ST_RUN;
              fault_d = 1'b0;
            end
          end
        end else begin
          duty_d  = duty_cmd;
          state_d = ST_RUN;
          fault_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_HALT;
        duty_d  = 8'd0;
      end
    endcase

    // Enables follow the next state so they stay aligned with the registered state
    motor_en_d = (state_d != ST_HALT);
    brake_d    = (state_d == ST_HALT);
  end

  always_ff @(posedge clk_1khz or posedge rst) begin
    if (rst) begin
      state_q    <= ST_HALT;
      duty_q     <= 8'd0;
      motor_en_q <= 1'b0;
      brake_q    <= 1'b1;
      fault_q    <= 1'b0;
      cnt_q      <= 4'd0;
      nack_q     <= 1'b0;
      quiet_q    <= '0;
      div_q      <= '0;
      rr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      motor_en_q <= motor_en_d;
      brake_q    <= brake_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
      nack_q     <= nack_d;
      quiet_q    <= quiet_d;
      div_q      <= div_d;
      rr_q       <= rr_d;
    end
  end

  assign duty_out      = duty_q;
  assign motor_en      = motor_en_q;
  assign brake         = brake_q;
  assign fault_latched = fault_q;
  assign fault_cnt     = cnt_q;
  assign restart_nack  = nack_q;
  assign state         = state_q;

endmodule

// File: tb/tb_motor_shutdown_seq.sv
// Directed bench for motor_shutdown_seq; expectations follow MOTOR_SHUTDOWN_SOFT_RAMP_EN when it is defined.
module tb_motor_shutdown_seq;
  logic       clk_1khz;
  logic       rst;
  logic       shtdwn_in;
  logic [7:0] duty_cmd;
  logic       restart_req;
  logic [7:0] duty_out;
  logic       motor_en;
  logic       brake;
  logic       fault_latched;
  logic [3:0] fault_cnt;
  logic       restart_nack;
  logic [1:0] state;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  localparam logic [1:0] RUN = 2'd0, RAMP = 2'd1, HALT = 2'd2, REARM = 2'd3;
`ifdef MOTOR_SHUTDOWN_SOFT_RAMP_EN
  localparam int RAMP_LEN = 4;
`else
  localparam int RAMP_LEN = 1;
`endif

  motor_shutdown_seq dut (
    .clk_1khz     (clk_1khz),
    .rst          (rst),
    .shtdwn_in    (shtdwn_in),
    .duty_cmd     (duty_cmd),
    .restart_req  (restart_req),
    .duty_out     (duty_out),
    .motor_en     (motor_en),
    .brake        (brake),
    .fault_latched(fault_latched),
    .fault_cnt    (fault_cnt),
    .restart_nack (restart_nack),
    .state        (state)
  );

  initial begin
    clk_1khz = 1'b0;
    forever #5 clk_1khz = ~clk_1khz;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_1khz);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] e_state, input logic [7:0] e_duty,
                         input logic e_en, input logic e_brk);
    chk({tag, ".state"}, 8'(state), 8'(e_state));
    chk({tag, ".duty"}, duty_out, e_duty);
    chk({tag, ".motor_en"}, 8'(motor_en), 8'(e_en));
    chk({tag, ".brake"}, 8'(brake), 8'(e_brk));
  endtask

  task automatic chk_reset(input string tag);
    chk_out(tag, HALT, 8'd0, 1'b0, 1'b1);
    chk({tag, ".fault_latched"}, 8'(fault_latched), 8'd0);
    chk({tag, ".fault_cnt"}, 8'(fault_cnt), 8'd0);
    chk({tag, ".nack"}, 8'(restart_nack), 8'd0);
  endtask

  initial begin
    rst = 1'b1;
    shtdwn_in = 1'b0;
    duty_cmd = 8'd128;
    restart_req = 1'b0;
    #3;
    chk_reset("reset");
    #20 rst = 1'b0;
    tick(1);
    chk_out("post_reset", HALT, 8'd0, 1'b0, 1'b1);

    // Early restart while quiet is only ~100: rejected with a single pulse
    tick(99);
    restart_req = 1'b1;
    tick(1);
    chk("early.nack", 8'(restart_nack), 8'd1);
    chk("early.state", 8'(state), 8'(HALT));
    tick(1);
    chk("held.nack", 8'(restart_nack), 8'd0);
    restart_req = 1'b0;

    // Shutdown in HALT clears the quiet count without counting a fault
    tick(97);
    shtdwn_in = 1'b1;
    tick(1);
    shtdwn_in = 1'b0;
    chk("halt_sd.cnt", 8'(fault_cnt), 8'd0);
    chk("halt_sd.state", 8'(state), 8'(HALT));
    tick(249);
    restart_req = 1'b1;
    tick(1);
    restart_req = 1'b0;
    chk("quiet249.nack", 8'(restart_nack), 8'd1);
    chk("quiet249.state", 8'(state), 8'(HALT));
    tick(1);
    restart_req = 1'b1;
    tick(1);
    restart_req = 1'b0;
    chk("accept.nack", 8'(restart_nack), 8'd0);
    chk_out("accept", REARM, 8'd0, 1'b1, 1'b0);

`ifdef MOTOR_SHUTDOWN_SOFT_RAMP_EN
    tick(4);
    chk_out("rearm.s1", REARM, 8'd16, 1'b1, 1'b0);
    tick(24);
    chk_out("rearm.s7", REARM, 8'd112, 1'b1, 1'b0);
    tick(4);
`else
    tick(1);
`endif
    chk_out("run", RUN, 8'd128, 1'b1, 1'b0);
    chk("run.fault", 8'(fault_latched), 8'd0);

    duty_cmd = 8'd200;
    tick(1);
    chk("run.track", duty_out, 8'd200);
    duty_cmd = 8'd128;
    tick(1);

    // Shutdown from RUN at duty 128
    shtdwn_in = 1'b1;
    tick(1);
    shtdwn_in = 1'b0;
    chk("sd1.cnt", 8'(fault_cnt), 8'd1);
    chk("sd1.fault", 8'(fault_latched), 8'd1);
`ifdef MOTOR_SHUTDOWN_SOFT_RAMP_EN
    chk_out("sd1", RAMP, 8'd128, 1'b1, 1'b0);
    tick(4);
    chk_out("ramp.s1", RAMP, 8'd112, 1'b1, 1'b0);
    tick(24);
    chk_out("ramp.s7", RAMP, 8'd16, 1'b1, 1'b0);
    tick(4);
`else
    chk_out("sd1", RAMP, 8'd0, 1'b1, 1'b0);
    tick(1);
`endif
    chk_out("halt1", HALT, 8'd0, 1'b0, 1'b1);
    chk("halt1.fault", 8'(fault_latched), 8'd1);

    // Clamp: command 10 reached in one step, ramp down from 10 lands on 0
    tick(250);
    duty_cmd = 8'd10;
    restart_req = 1'b1;
    tick(1);
    restart_req = 1'b0;
    chk("clamp.rearm", 8'(state), 8'(REARM));
    tick(RAMP_LEN);
    chk_out("clamp.run", RUN, 8'd10, 1'b1, 1'b0);
    chk("clamp.fault", 8'(fault_latched), 8'd0);
    tick(1);
    shtdwn_in = 1'b1;
    tick(1);
    shtdwn_in = 1'b0;
    chk("sd2.cnt", 8'(fault_cnt), 8'd2);
    chk("sd2.state", 8'(state), 8'(RAMP));
    tick(RAMP_LEN);
    chk_out("clamp.halt", HALT, 8'd0, 1'b0, 1'b1);

    // Fifteen more shutdowns, taken from REARM, saturate the counter at 15
    for (int i = 0; i < 15; i++) begin
      tick(250);
      restart_req = 1'b1;
      tick(1);
      restart_req = 1'b0;
      shtdwn_in = 1'b1;
      tick(1);
      shtdwn_in = 1'b0;
      chk("sat.state", 8'(state), 8'(RAMP));
      chk("sat.cnt", 8'(fault_cnt), 8'((i + 3 > 15) ? 15 : i + 3));
      tick(RAMP_LEN);
    end
    chk_out("sat.halt", HALT, 8'd0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a ramp
    tick(250);
    duty_cmd = 8'd128;
    restart_req = 1'b1;
    tick(1);
    restart_req = 1'b0;
`ifdef MOTOR_SHUTDOWN_SOFT_RAMP_EN
    tick(32);
`else
    tick(1);
`endif
    chk("mid.run", 8'(state), 8'(RUN));
    tick(1);
    shtdwn_in = 1'b1;
    tick(1);
    shtdwn_in = 1'b0;
`ifdef MOTOR_SHUTDOWN_SOFT_RAMP_EN
    tick(6);
    chk("mid.duty", duty_out, 8'd112);
`endif
    chk("mid.ramp", 8'(state), 8'(RAMP));
    #2 rst = 1'b1;
    #1;
    chk_reset("async_rst");
    #3 rst = 1'b0;
    tick(2);
    chk_out("after_rst", HALT, 8'd0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
